// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default operand/result width
//   cnt_width()   : bit-slice counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  // The guard keeps the width at one bit or more for degenerate arguments.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Full_Adder: the team's 1-bit full-adder datapath cell.
// Ports:
//   bits     in  [1:0]  operand bits {b, a}
//   carryIn  in  1      carry into this bit slice
//   sum      out 1      sum bit
//   carryOut out 1      carry out of this bit slice
module Full_Adder (
  input  logic [1:0] bits,
  input  logic       carryIn,
  output logic       sum,
  output logic       carryOut
);

  assign sum      = bits[0] ^ bits[1] ^ carryIn;
  assign carryOut = (bits[0] & bits[1]) | (carryIn & (bits[0] ^ bits[1]));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller. Runs a single Full_Adder
// cell across WIDTH-bit operands, LSB first, one bit per clock, holding the
// carry in a flop between slices.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port; a - b).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   operation request, honoured only while idle
//   a, b     in   [WIDTH-1:0] operands, captured on an accepted start
//   carryIn  in   initial carry, captured on an accepted start
//   sub      in   (SERIAL_ADDER_SUB_EN only) 1 = compute a - b
//   busy     out  high while an operation is in progress (RUN/DONE)
//   done     out  one-cycle pulse when sum/carryOut become valid
//   sum      out  [WIDTH-1:0] result, held until the next accepted start
//   carryOut out  final carry (no-borrow flag when subtracting)
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Subtraction is a + ~b + 1: invert B and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : carryIn;
`else
  assign b_load     = b;
  assign carry_load = carryIn;
`endif

  Full_Adder u_fa (
    .bits     ({b_sr[0], a_sr[0]}),
    .carryIn  (carry),
    .sum      (fa_sum),
    .carryOut (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shift registers, carry flop, counter and registered outputs.
  // sum/carryOut/done are registered out of DONE, so they appear the cycle
  // after DONE, while the controller is already back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b_load;
            carry    <= carry_load;
            sum_sr   <= '0;
            cnt      <= '0;
            sum      <= '0;
            carryOut <= 1'b0;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the first (LSB) slice ends up
          // in bit 0 after WIDTH shifts.
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          sum      <= sum_sr;
          carryOut <= carry;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         sub;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryIn  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carry_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the captured operands.
  function automatic logic [W:0] ref_result(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                            input logic tc, input logic ts);
    logic [W:0] full;
`ifdef SERIAL_ADDER_SUB_EN
    if (ts) full = {1'b0, ta} + {1'b0, ~tb} + (W+1)'(1);
    else    full = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
`else
    full = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
`endif
    return full;
  endfunction

  // One operation: start pulse, then a fixed 12-cycle observation window.
  // Operands are scrambled after acceptance; optionally a second start is
  // injected mid-run (inject_at > 0) with all-ones operands.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input int inject_at, input string tag);
    logic [W:0] exp;
    int lat, npulse;
    logic [W-1:0] s_cap;
    logic c_cap;
    exp = ref_result(ta, tb, tc, ts);
    lat = -1; npulse = 0; s_cap = '0; c_cap = 1'b0;
    a = ta; b = tb; carry_in = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom); sub = 1'($urandom);
      if (k == inject_at) begin
        a = '1; b = '1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (lat < 0) begin
          lat = k; s_cap = sum; c_cap = carry_out;
          check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_pulses"}, 32'(npulse), 32'd1);
    check({tag, "_sum"}, 32'(s_cap), 32'(exp[W-1:0]));
    check({tag, "_cout"}, 32'(c_cap), 32'(exp[W]));
    check({tag, "_sum_held"}, 32'(sum), 32'(exp[W-1:0]));
  endtask

  initial begin
    int n, gap;
    logic [W-1:0] s0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed adds
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "add_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "add_ff_ff_c");

    // Start while busy is ignored
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, "ignore_start");

    // Reset in the middle of RUN
    a = 8'hA5; b = 8'h5A; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("midrst_no_done", 32'(n), 32'd0);
    run_op(8'h77, 8'h11, 1'b1, 1'b0, 0, "after_rst");

    // Back-to-back with start held high
    a = 8'h01; b = 8'h01; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
    gap = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #1;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_sum", 32'(sum), 32'h02);
    for (int p = 0; p < 2; p++) begin
      gap = 0; s0 = '0;
      for (int k = 1; k <= 15; k++) begin
        @(posedge clk); #1;
        if (done) begin
          gap = k;
          break;
        end
        if (k == 1) begin
          s0 = sum;
          check("b2b_sum_cleared", 32'(sum), 32'd0);
        end else begin
          check("b2b_sum_stable", 32'(sum), 32'(s0));
        end
      end
      check("b2b_period", 32'(gap), 32'd10);
      check("b2b_sum", 32'(sum), 32'h02);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, "sub_10_01");
    run_op(8'h00, 8'h01, 1'b0, 1'b1, 0, "sub_00_01");
`endif

    // Randomized operations against the reference
    for (int i = 0; i < 16; i++) begin
      logic ts;
`ifdef SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), ts, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
